// File: rtl/func_pkg.sv
// func_pkg: shared width and sequencer state encoding for the func core, its
// sequencer and the bench.
package func_pkg;

  localparam int FUNC_DW = 8;
  localparam int WDOG_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  // The two states in which the sequencer waits on the core's busy line.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_WAIT_BUSY) || (s == S_WAIT_DONE);
  endfunction

endpackage

// File: rtl/func_seq_wdog.sv
// func_seq_wdog: per-phase cycle counter for the sequencer's busy watchdog.
// Only instantiated when FUNC_SEQ_TIMEOUT_EN is defined.
module func_seq_wdog
  import func_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] cnt_q;

  // Counter value k during the (k+1)-th cycle of a phase, so expiry fires in
  // the TIMEOUT_CYCLES-th cycle and the transition lands on its closing edge.
  assign expired = enable && (cnt_q == LIMIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/func_seq.sv
// func_seq: start/busy handshake initiator for one func core, valid/ready on
// both sides. Optional per-phase watchdog: define FUNC_SEQ_TIMEOUT_EN.
module func_seq
  import func_pkg::*;
#(
  parameter int          DW             = FUNC_DW,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [DW-1:0] req_a_i,
  input  logic [DW-1:0] req_b_i,
  output logic [DW-1:0] func_a_o,
  output logic [DW-1:0] func_b_o,
  output logic          func_start_o,
  input  logic          func_busy_i,
  input  logic [DW-1:0] func_y_bi,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_y_o,
  output logic [DW-1:0] rsp_a_o,
  output logic [DW-1:0] rsp_b_o,
  output logic          rsp_err_o,
  output logic          busy_o
);

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("func_seq: TIMEOUT_CYCLES must be within 2..65535");
  end

  state_t        state_q, state_d;
  logic [DW-1:0] op_a_q, op_b_q;
  logic [DW-1:0] rsp_y_q, rsp_a_q, rsp_b_q;
  logic          wdog_expired;
  logic          result_ok;
  logic          capture;

`ifdef FUNC_SEQ_TIMEOUT_EN
  logic wdog_clear;
  logic rsp_err_q;

  // Any state change restarts the count, so each wait phase gets its own budget.
  assign wdog_clear = (state_d != state_q);

  func_seq_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (wdog_clear),
    .enable (is_wait_state(state_q)),
    .expired(wdog_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_err_q <= 1'b0;
    end else if (capture) begin
      rsp_err_q <= !result_ok;
    end
  end

  assign rsp_err_o = rsp_err_q;
`else
  assign wdog_expired = 1'b0;
  assign rsp_err_o    = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks, so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first, so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (req_valid_i) state_d = S_START;
      S_START:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (func_busy_i)       state_d = S_WAIT_DONE;
        else if (wdog_expired) state_d = S_RESP;
      end
      S_WAIT_DONE: if (!func_busy_i || wdog_expired) state_d = S_RESP;
      S_RESP:      if (rsp_ready_i) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // A genuine busy fall wins over a watchdog expiry in the same cycle.
  assign result_ok = (state_q == S_WAIT_DONE) && !func_busy_i;
  assign capture   = is_wait_state(state_q) && (state_d == S_RESP);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: data registers are reset as well; their reset values are
      // visible on the ports and are part of the block's reset state.
      op_a_q  <= '0;
      op_b_q  <= '0;
      rsp_y_q <= '0;
      rsp_a_q <= '0;
      rsp_b_q <= '0;
    end else begin
      if (req_ready_o && req_valid_i) begin
        op_a_q <= req_a_i;
        op_b_q <= req_b_i;
      end
      if (capture) begin
        rsp_a_q <= op_a_q;
        rsp_b_q <= op_b_q;
        rsp_y_q <= result_ok ? func_y_bi : '0;
      end
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign func_start_o = (state_q == S_START);
  assign rsp_valid_o  = (state_q == S_RESP);
  assign busy_o       = (state_q != S_IDLE);
  assign func_a_o     = op_a_q;
  assign func_b_o     = op_b_q;
  assign rsp_y_o      = rsp_y_q;
  assign rsp_a_o      = rsp_a_q;
  assign rsp_b_o      = rsp_b_q;

endmodule

// File: tb/tb_func_seq.sv
// tb_func_seq: func_seq driven against a behavioural func core
// (y = a*a + floor(cbrt(b)), mod 2^8) with a response scoreboard.
module tb_func_seq;
  import func_pkg::*;

  localparam int DW = FUNC_DW;
  localparam int TO = 16;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            dur;
    bit            early;
    logic [DW-1:0] y;
  } vec_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] y;
    logic          err;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [DW-1:0] req_a_i, req_b_i;
  logic [DW-1:0] func_a_o, func_b_o;
  logic          func_start_o;
  logic          func_busy_i;
  logic [DW-1:0] func_y_bi;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_y_o, rsp_a_o, rsp_b_o;
  logic          rsp_err_o;
  logic          busy_o;

  int   total = 0;
  int   bad   = 0;
  int   start_cnt = 0;
  int   n_sent = 0;
  exp_t sb[$];
  logic [DW-1:0] cur_a = '0, cur_b = '0;

  int   core_dur   = 1;
  bit   core_early = 1'b0;
  bit   core_stuck = 1'b0;
  logic core_busy_q;
  int   core_left;
  logic [DW-1:0] core_y;

  func_seq #(.DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .func_a_o(func_a_o), .func_b_o(func_b_o),
    .func_start_o(func_start_o), .func_busy_i(func_busy_i), .func_y_bi(func_y_bi),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_y_o(rsp_y_o), .rsp_a_o(rsp_a_o), .rsp_b_o(rsp_b_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 500000", $time);
    $fatal(1);
  end

  function automatic logic [DW-1:0] func_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int ia = int'(a);
    int ib = int'(b);
    int r  = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= ib) r++;
    return DW'(ia * ia + r);
  endfunction

  // Behavioural core: busy for core_dur cycles after the start pulse, result
  // computed from the operand ports at the busy fall.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_busy_q <= 1'b0;
      core_left   <= 0;
      core_y      <= '0;
    end else if (func_start_o && !core_stuck) begin
      core_busy_q <= 1'b1;
      core_left   <= core_dur;
    end else if (core_busy_q) begin
      if (core_left <= 1) begin
        core_busy_q <= 1'b0;
        core_y      <= func_ref(func_a_o, func_b_o);
      end else begin
        core_left <= core_left - 1;
      end
    end
  end

  assign func_busy_i = core_busy_q | (core_early & func_start_o);
  assign func_y_bi   = core_y;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ctrl"}, {req_ready_o, func_start_o, rsp_valid_o, rsp_err_o, busy_o}, 5'b10000);
    check({tag, " data"}, {func_a_o, func_b_o, rsp_y_o, rsp_a_o, rsp_b_o}, '0);
  endtask

  // Response scoreboard, start-pulse counter and in-flight operand monitor.
  bit   prev_pop = 1'b0;
  exp_t mon_e;
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_pop = 1'b0;
    end else begin
      if (prev_pop) check("rsp_valid one cycle", rsp_valid_o, 1'b0);
      prev_pop = 1'b0;
      if (rsp_valid_o && rsp_ready_i) begin
        if (sb.size() == 0) begin
          check("rsp with empty scoreboard", rsp_valid_o, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_y", rsp_y_o, mon_e.y);
          check("rsp_ab", {rsp_a_o, rsp_b_o}, {mon_e.a, mon_e.b});
          check("rsp_err", rsp_err_o, mon_e.err);
        end
        prev_pop = 1'b1;
      end
      if (func_start_o) start_cnt++;
      if (busy_o) begin
        check("req_ready low in flight", req_ready_o, 1'b0);
        check("operands held", {func_a_o, func_b_o}, {cur_a, cur_b});
      end
    end
  end

  // Holds req_valid high (garbage operands while not ready) until accepted.
  task automatic send(input vec_t v, input bit push, input bit err, input bit keep_valid,
                      output int waited);
    bit   acc = 1'b0;
    exp_t e;
    waited = 0;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk_i);
      req_valid_i = 1'b1;
      if (req_ready_o) begin
        req_a_i    = v.a;
        req_b_i    = v.b;
        core_dur   = v.dur;
        core_early = v.early;
        waited     = c;
        @(posedge clk_i);
        acc   = 1'b1;
        cur_a = v.a;
        cur_b = v.b;
        n_sent++;
        if (push) begin
          e.a = v.a; e.b = v.b; e.y = err ? '0 : v.y; e.err = err;
          sb.push_back(e);
        end
        #1;
        if (!keep_valid) req_valid_i = 1'b0;
      end
      req_a_i = DW'($urandom);
      req_b_i = DW'($urandom);
    end
    check("request accepted", acc, 1'b1);
    if (acc) begin
      @(negedge clk_i);
      check("start after accept", func_start_o, 1'b1);
      check("operands latched", {func_a_o, func_b_o}, {v.a, v.b});
      @(negedge clk_i);
      check("start one cycle", func_start_o, 1'b0);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 300 && (sb.size() != 0 || busy_o); c++) @(negedge clk_i);
    check(name, {sb.size() == 0, busy_o}, 2'b10);
  endtask

  vec_t vecs[7];
  vec_t hv, hv2, rv, sv;
  int   waited;
  bit   seen;

  initial begin
    vecs[0] = '{8'd0,   8'd1,   1, 1'b0, 8'd1};
    vecs[1] = '{8'd15,  8'd255, 3, 1'b0, 8'd231};
    vecs[2] = '{8'd8,   8'd64,  2, 1'b1, 8'd68};
    vecs[3] = '{8'd3,   8'd27,  5, 1'b0, 8'd12};
    vecs[4] = '{8'd16,  8'd8,   1, 1'b1, 8'd2};
    vecs[5] = '{8'd255, 8'd0,   4, 1'b0, 8'd1};
    vecs[6] = '{8'd10,  8'd125, 2, 1'b0, 8'd105};
    hv  = '{8'h5a, 8'd216, 3, 1'b0, 8'h30};   // 0x5a^2=0x1fa4 -> 0xa4, +6 = 0xaa? see below
    hv.y  = 8'haa;
    hv2 = '{8'd2, 8'd9, 2, 1'b0, 8'd6};
    rv  = '{8'd7, 8'd7, 20, 1'b0, 8'd50};
    sv  = '{8'h3c, 8'hc3, 1, 1'b0, 8'd0};

    rst_i = 1'b1; req_valid_i = 1'b0; req_a_i = '0; req_b_i = '0; rsp_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check_reset("in reset");
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_reset("after reset");

    // Back-to-back table with req_valid held high and rsp_ready held high.
    foreach (vecs[i]) send(vecs[i], 1'b1, 1'b0, (i != $size(vecs) - 1), waited);
    wait_drain("table drained");
    check("start pulses after table", start_cnt, n_sent);

    // Response back-pressure: 5 cycles in RESP with rsp_ready low.
    @(posedge clk_i); #1 rsp_ready_i = 1'b0;
    send(hv, 1'b1, 1'b0, 1'b1, waited);
    for (int c = 0; c < 100 && !rsp_valid_o; c++) @(negedge clk_i);
    check("hold rsp reached", rsp_valid_o, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk_i);
      check("hold valid", {rsp_valid_o, req_ready_o}, 2'b10);
      check("hold fields", {rsp_y_o, rsp_a_o, rsp_b_o}, {hv.y, hv.a, hv.b});
    end
    @(posedge clk_i); #1 rsp_ready_i = 1'b1;
    send(hv2, 1'b1, 1'b0, 1'b0, waited);
    check("accept right after rsp handshake", waited, 1);
    wait_drain("hold drained");

    // Reset during WAIT_DONE: no response, all outputs back to reset values.
    send(rv, 1'b0, 1'b0, 1'b0, waited);
    repeat (2) @(negedge clk_i);
    check("in flight before reset", {busy_o, func_busy_i}, 2'b11);
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(negedge clk_i);
    check_reset("async reset");
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_reset("after mid reset");
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk_i);
      seen |= rsp_valid_o;
    end
    check("no rsp after reset", seen, 1'b0);

    // Core never raises busy.
    core_stuck = 1'b1;
`ifdef FUNC_SEQ_TIMEOUT_EN
    send(sv, 1'b1, 1'b1, 1'b0, waited);
    repeat (TO - 1) @(negedge clk_i);
    check("timeout not early", rsp_valid_o, 1'b0);
    @(negedge clk_i);
    check("timeout rsp", {rsp_valid_o, rsp_err_o}, 2'b11);
    wait_drain("timeout drained");
`else
    send(sv, 1'b0, 1'b0, 1'b0, waited);
    repeat (40) @(negedge clk_i);
    check("stuck waits forever", {busy_o, rsp_valid_o, rsp_err_o}, 3'b100);
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_reset("stuck recovered");
`endif
    core_stuck = 1'b0;

    repeat (3) @(negedge clk_i);
    check("scoreboard empty", sb.size(), 0);
    check("start pulse count", start_cnt, n_sent);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
